// File: rtl/tt_mux_sel_ctrl_if.sv
// tt_mux_sel_ctrl_if: control, pad and user-bus signals of one TT user-design mux.
interface tt_mux_sel_ctrl_if #(
    parameter int N_BLK = 32,
    parameter int N_I   = 10,
    parameter int N_O   = 8,
    parameter int N_IO  = 8
);
    localparam int W = N_O + 2 * N_IO;
    logic                  sel_inc;
    logic                  ena;
    logic [9:0]            sel_addr;
    logic [N_BLK-1:0]      blk_ena;
    logic                  um_rst_n;
    logic [N_I-1:0]        ui_in;
    logic [N_IO-1:0]       uio_in;
    logic [N_I+N_IO-1:0]   um_iw;
    logic [N_BLK*W-1:0]    um_ow;
    logic [N_O-1:0]        uo_out;
    logic [N_IO-1:0]       uio_out;
    logic [N_IO-1:0]       uio_oe;
    logic                  k_zero;
    logic                  k_one;
    modport master (
        output sel_inc, ena, ui_in, uio_in, um_ow,
        input  sel_addr, blk_ena, um_rst_n, um_iw, uo_out, uio_out, uio_oe, k_zero, k_one
    );
    modport slave (
        input  sel_inc, ena, ui_in, uio_in, um_ow,
        output sel_addr, blk_ena, um_rst_n, um_iw, uo_out, uio_out, uio_oe, k_zero, k_one
    );
endinterface

// File: rtl/tt_mux_sel_ctrl.sv
// tt_mux_sel_ctrl: block-select and I/O routing for one TT user-design mux.
// Optional macro TT_RST_STRETCH_EN holds the user reset for 8 cycles after selection.
module tt_mux_sel_ctrl #(
    parameter int MUX_ID = 12,
    parameter int N_BLK  = 32,
    parameter int N_I    = 10,
    parameter int N_O    = 8,
    parameter int N_IO   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tt_mux_sel_ctrl_if.slave   bus
);
    localparam int W = N_O + 2 * N_IO;
    logic [9:0]       sel_addr_q, sel_addr_d;
    logic [N_BLK-1:0] blk_ena_q, blk_ena_d;
    logic             match;
    logic             any_sel;
    logic [W-1:0]     mux_w;
    always_comb begin
        sel_addr_d = bus.sel_inc ? sel_addr_q + 10'd1 : sel_addr_q;
        match      = bus.ena && (sel_addr_q[9:5] == 5'(MUX_ID));
        blk_ena_d  = '0;
        for (int i = 0; i < N_BLK; i++)
            blk_ena_d[i] = match && (sel_addr_q[4:0] == 5'(i));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_addr_q <= '0;
            blk_ena_q  <= '0;
        end else begin
            sel_addr_q <= sel_addr_d;
            blk_ena_q  <= blk_ena_d;
        end
    end
`ifdef TT_RST_STRETCH_EN
    logic [3:0] cnt_q, cnt_d;
    logic       chg;
    // moving to a different block restarts the stretch so the new block sees a full reset
    always_comb begin
        chg   = (|blk_ena_q) && (blk_ena_d != blk_ena_q);
        cnt_d = (!match || chg) ? 4'd0 : (cnt_q[3] ? cnt_q : cnt_q + 4'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign bus.um_rst_n = cnt_q[3];
`else
    logic rst_q, rst_d;
    always_comb rst_d = match;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 1'b0;
        else        rst_q <= rst_d;
    end
    assign bus.um_rst_n = rst_q;
`endif
    // blk_ena is one-hot, so OR-ing the gated slices selects exactly one block
    always_comb begin
        mux_w = '0;
        for (int i = 0; i < N_BLK; i++)
            mux_w |= blk_ena_q[i] ? bus.um_ow[i*W +: W] : '0;
    end
    assign any_sel      = |blk_ena_q;
    assign bus.sel_addr = sel_addr_q;
    assign bus.blk_ena  = blk_ena_q;
    assign bus.um_iw    = any_sel ? {bus.uio_in, bus.ui_in} : '0;
    assign bus.uo_out   = mux_w[0 +: N_O];
    assign bus.uio_out  = mux_w[N_O +: N_IO];
    assign bus.uio_oe   = mux_w[N_O+N_IO +: N_IO];
    assign bus.k_zero   = 1'b0;
    assign bus.k_one    = 1'b1;
endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// tb_tt_mux_sel_ctrl: directed self-checking bench for tt_mux_sel_ctrl.
module tb_tt_mux_sel_ctrl;
`ifdef TT_RST_STRETCH_EN
    localparam int   RST_LAT = 8;
    localparam logic SIM_RST = 1'b0;
`else
    localparam int   RST_LAT = 1;
    localparam logic SIM_RST = 1'b1;
`endif
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    tt_mux_sel_ctrl_if bus ();
    tt_mux_sel_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.sel_inc = 1'b0;
        bus.ena = 1'b0;
        bus.ui_in = 10'h155;
        bus.uio_in = 8'h66;
        for (int i = 0; i < 32; i++)
            bus.um_ow[i*24 +: 24] = {8'(i + 8'h80), 8'(i + 8'h40), 8'(i + 8'h10)};
        bus.um_ow[0 +: 24]  = {8'hF0, 8'h3C, 8'hA5};
        bus.um_ow[24 +: 24] = {8'h0F, 8'hC3, 8'h5A};
        #23;
        chk("rst sel_addr", 32'(bus.sel_addr), 32'd0);
        chk("rst blk_ena", 32'(bus.blk_ena), 32'd0);
        chk("rst um_rst_n", 32'(bus.um_rst_n), 32'd0);
        chk("rst uo_out", 32'(bus.uo_out), 32'd0);
        chk("rst uio_oe", 32'(bus.uio_oe), 32'd0);
        chk("rst um_iw", 32'(bus.um_iw), 32'd0);
        chk("rst k_zero", 32'(bus.k_zero), 32'd0);
        chk("rst k_one", 32'(bus.k_one), 32'd1);
        rst_n = 1'b1;
        step();
        step();
        chk("post-rst sel_addr", 32'(bus.sel_addr), 32'd0);
        chk("post-rst blk_ena", 32'(bus.blk_ena), 32'd0);
    endtask
    task automatic test_stepping();
        for (int i = 0; i < 381; i++) begin
            bus.sel_inc = 1'b1; step();
            bus.sel_inc = 1'b0; step();
        end
        chk("step 381", 32'(bus.sel_addr), 32'd381);
        bus.sel_inc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.sel_inc = 1'b0;
        step();
        chk("hold +3 to 384", 32'(bus.sel_addr), 32'd384);
        chk("idle blk_ena", 32'(bus.blk_ena), 32'd0);
        for (int i = 0; i < 639; i++) begin
            bus.sel_inc = 1'b1; step();
            bus.sel_inc = 1'b0; step();
        end
        chk("step 1023", 32'(bus.sel_addr), 32'd1023);
        bus.sel_inc = 1'b1; step();
        bus.sel_inc = 1'b0; step();
        chk("wrap to 0", 32'(bus.sel_addr), 32'd0);
        bus.sel_inc = 1'b1;
        for (int i = 0; i < 384; i++) step();
        bus.sel_inc = 1'b0;
        step();
        chk("back to 384", 32'(bus.sel_addr), 32'd384);
    endtask
    task automatic test_enable();
        bus.ena = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("um_rst_n cyc%0d", k), 32'(bus.um_rst_n), 32'(k >= RST_LAT));
        end
        chk("ena blk_ena", bus.blk_ena, 32'h0000_0001);
        chk("ena uo_out", 32'(bus.uo_out), 32'hA5);
        chk("ena uio_out", 32'(bus.uio_out), 32'h3C);
        chk("ena uio_oe", 32'(bus.uio_oe), 32'hF0);
        chk("ena um_iw", 32'(bus.um_iw), {14'd0, 8'h66, 10'h155});
        bus.ena = 1'b0;
        step();
        chk("drop um_rst_n", 32'(bus.um_rst_n), 32'd0);
        chk("drop blk_ena", 32'(bus.blk_ena), 32'd0);
        chk("drop uio_oe", 32'(bus.uio_oe), 32'd0);
        chk("drop um_iw", 32'(bus.um_iw), 32'd0);
    endtask
    task automatic test_simultaneous();
        bus.ena = 1'b1;
        bus.sel_inc = 1'b1;
        step();
        chk("sim blk_ena pre", bus.blk_ena, 32'h0000_0001);
        chk("sim sel_addr", 32'(bus.sel_addr), 32'd385);
        bus.sel_inc = 1'b0;
        step();
        chk("sim blk_ena next", bus.blk_ena, 32'h0000_0002);
        chk("sim uo_out blk1", 32'(bus.uo_out), 32'h5A);
        chk("sim uio_oe blk1", 32'(bus.uio_oe), 32'h0F);
        chk("sim um_rst_n", 32'(bus.um_rst_n), 32'(SIM_RST));
        bus.ena = 1'b0;
        step();
    endtask
    task automatic test_mismatch();
        bus.sel_inc = 1'b1;
        for (int i = 0; i < 32; i++) step();
        bus.sel_inc = 1'b0;
        bus.ena = 1'b1;
        step();
        chk("mis sel_addr", 32'(bus.sel_addr), 32'd417);
        step();
        chk("mis blk_ena", bus.blk_ena, 32'd0);
        chk("mis uo_out", 32'(bus.uo_out), 32'd0);
        chk("mis um_iw", 32'(bus.um_iw), 32'd0);
        chk("mis um_rst_n", 32'(bus.um_rst_n), 32'd0);
        bus.ena = 1'b0;
    endtask
    task automatic test_async_reset();
        bus.sel_inc = 1'b1;
        for (int i = 0; i < 991; i++) step();
        bus.sel_inc = 1'b0;
        bus.ena = 1'b1;
        step();
        step();
        chk("pre-arst sel_addr", 32'(bus.sel_addr), 32'd384);
        chk("pre-arst blk_ena", bus.blk_ena, 32'h0000_0001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst sel_addr", 32'(bus.sel_addr), 32'd0);
        chk("arst blk_ena", bus.blk_ena, 32'd0);
        chk("arst um_rst_n", 32'(bus.um_rst_n), 32'd0);
        chk("arst uo_out", 32'(bus.uo_out), 32'd0);
        chk("arst k_one", 32'(bus.k_one), 32'd1);
        bus.ena = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("resume sel_addr", 32'(bus.sel_addr), 32'd0);
        chk("resume blk_ena", bus.blk_ena, 32'd0);
    endtask
    initial begin
        test_reset();
        test_stepping();
        test_enable();
        test_simultaneous();
        test_mismatch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tt_mux_sel_ctrl.md
Name: tt_mux_sel_ctrl

Overview:
- Block-select and I/O routing controller for one user-design mux in the TT multiplexer.
- A 10-bit selection address is stepped by an increment strobe:
  - address[9:5] = mux ID;
  - address[4:0] = block ID within the mux.
- When enabled and the mux ID matches, exactly one of 32 user blocks gets its enable and reset release.
- Pad inputs are broadcast to the user bus; the selected block's outputs are muxed back to the pads. Tie-off constants are also provided.

Parameters:
- MUX_ID, 12, 5-bit ID of this mux instance.
- N_BLK, 32, user blocks on this mux (max 32, indexed by address[4:0]).
- N_I, 10, dedicated user inputs.
- N_O, 8, dedicated user outputs.
- N_IO, 8, user bidirectional pins.

Ports:
- clk  in  1  control clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sel_inc  in  1  selection-address increment strobe.
- ena  in  1  enable request for the addressed block.
- sel_addr  out  10  current selection address.
- blk_ena  out  N_BLK  one-hot user-block enable.
- um_rst_n  out  1  user reset, active low, common to all blocks.
- ui_in  in  N_I  dedicated inputs from pads.
- uio_in  in  N_IO  bidir inputs from pads.
- um_iw  out  N_I+N_IO  input bus to blocks, {uio_in, ui_in}.
- um_ow  in  N_BLK*(N_O+2*N_IO)  per-block outputs. Block i is slice [i*W +: W], W=N_O+2*N_IO; low to high within the slice: uo_out, uio_out, uio_oe.
- uo_out  out  N_O  dedicated outputs to pads.
- uio_out  out  N_IO  bidir output values to pads.
- uio_oe  out  N_IO  bidir output enables, 1 = drive.
- k_zero  out  1  constant 0.
- k_one  out  1  constant 1.

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers to 0:
  - sel_addr = 0, ena_r = 0, blk_ena = 0, um_rst_n = 0, reset-stretch counter = 0.
- sel_addr:
  - Rising clk with sel_inc=1 increments by 1; 1023 wraps to 0.
  - Holding sel_inc high N cycles advances N.
  - sel_inc=0 holds the value.
- ena_r: registered copy of ena, 1-cycle latency.
- blk_ena[i]:
  - Registered each clk as ena & (sel_addr[9:5]==MUX_ID) & (sel_addr[4:0]==i).
  - Uses the pre-increment sel_addr when sel_inc and ena are sampled in the same cycle.
  - Indices >= N_BLK are never set; an address selecting them leaves blk_ena all zero.
  - At most one bit set. It follows address changes with 1-cycle latency even while ena stays high.
- any_sel = |blk_ena.
- um_iw = any_sel ? {uio_in, ui_in} : 0. Combinational.
- Output mux, combinational, from blk_ena and um_ow:
  - Selected block's slice drives uo_out, uio_out, uio_oe.
  - any_sel=0 forces uo_out=0, uio_out=0, uio_oe=0 (pads released).
- um_rst_n: see Optional Feature. Any clk with ena=0 or mux mismatch forces um_rst_n=0 on the next edge.
- k_zero=0, k_one=1 at all times, including during reset.
- Deassertion of rst_n mid-operation: resumes from address 0, nothing enabled.

Optional Feature:
- Macro TT_RST_STRETCH_EN.
- Defined:
  - A 4-bit counter clears while (ena & mux match) is 0.
  - While it is 1, the counter increments each clk, saturating at 8.
  - um_rst_n = counter[3], so the user reset releases 8 clk cycles after the first enabled cycle.
  - An address change to a different block clears the counter, so the reset is re-stretched.
- Not defined: um_rst_n = registered (ena & mux match), 1-cycle latency. No counter.

Test Plan:
- Reset: rst_n=0 -> sel_addr=0, blk_ena=0, um_rst_n=0, uo_out=0, uio_oe=0, k_zero=0, k_one=1. Release rst_n -> values unchanged until stimulus.
- Stepping: pulse sel_inc 384 times (one cycle high, one low) -> sel_addr=384 (mux 12, block 0). 640 further increments -> wraps to 0.
- Enable at address 384, ena=1:
  - Next edge: blk_ena=32'h0000_0001.
  - Block 0 um_ow slice uo=8'hA5, uio_out=8'h3C, uio_oe=8'hF0 -> pads show A5/3C/F0.
  - ui_in=10'h155 -> um_iw[9:0]=10'h155.
- Mismatch: address 385+32=417 (mux 13) with ena=1 -> blk_ena=0, uo_out=0, um_iw=0, um_rst_n=0.
- Reset stretch (TT_RST_STRETCH_EN defined): ena rises at address 384 -> um_rst_n low for 8 cycles, then high. Drop ena -> um_rst_n=0 after 1 cycle. Undefined build -> um_rst_n high 1 cycle after ena.
- Simultaneous: sel_inc=1 and ena=1 at address 384 -> blk_ena bit 0 asserted for that cycle, then bit 1 next cycle as address becomes 385. rst_n low mid-run -> immediate clear.
